// File: rtl/receiver_buffer.sv
// Double-buffered UART receive buffer: packs 16 bytes (MSB byte first) into a
// 128-bit block for the AES core, with overflow detection and an inter-byte timeout.
//
// state | meaning
// IDLE  | no partial block; byte_count = 0, idle counter frozen
// FILL  | 1..15 bytes collected; idle counter runs between strobes
module receiver_buffer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_done,
  input  logic         block_ack,
  output logic [127:0] block_out,
  output logic         block_valid,
  output logic [3:0]   byte_count,
  output logic         overflow,
  output logic         timeout
);

  localparam int unsigned LIM = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
  localparam int          CW  = $clog2(LIM + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LIM - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LIM);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state;
  // Only 15 bytes are ever held; the 16th comes straight from rx_data on completion.
  logic [119:0]    shift;
  logic [CW-1:0]   idle_cnt;
  logic [127:0]    next_shift;

  assign next_shift = {shift, rx_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shift       <= '0;
      idle_cnt    <= '0;
      block_out   <= '0;
      block_valid <= 1'b0;
      byte_count  <= 4'd0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      // Plain acknowledge; a same-cycle completion below overrides it.
      if (block_ack && block_valid) block_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_done) begin
            shift      <= next_shift[119:0];
            byte_count <= 4'd1;
            idle_cnt   <= '0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (rx_done) begin
            idle_cnt <= '0;
            if (byte_count == 4'd15) begin
              shift      <= '0;
              byte_count <= 4'd0;
              state      <= IDLE;
              if (!block_valid || block_ack) begin
                block_out   <= next_shift;
                block_valid <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              shift      <= next_shift[119:0];
              byte_count <= byte_count + 4'd1;
            end
          end else if (TO_EN && idle_cnt == CNT_LAST) begin
            // Limit reached with no byte this cycle: drop the partial block.
            shift      <= '0;
            byte_count <= 4'd0;
            idle_cnt   <= '0;
            state      <= IDLE;
            timeout    <= 1'b1;
          end else if (idle_cnt != CNT_MAX) begin
            idle_cnt <= idle_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receiver_buffer.sv
// Directed self-checking bench for receiver_buffer (TIMEOUT_CYCLES = 50).
module tb_receiver_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_done;
  logic         block_ack;
  logic [127:0] block_out;
  logic         block_valid;
  logic [3:0]   byte_count;
  logic         overflow;
  logic         timeout;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  receiver_buffer #(.TIMEOUT_CYCLES(50)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .block_ack   (block_ack),
    .block_out   (block_out),
    .block_valid (block_valid),
    .byte_count  (byte_count),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset && timeout) pulses++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] start, input logic [7:0] step);
    logic [127:0] v;
    logic [7:0]   b;
    v = '0;
    b = start;
    for (int i = 0; i < 16; i++) begin
      v = {v[119:0], b};
      b = b + step;
    end
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] start, input logic [7:0] step, input int n);
    logic [7:0] b;
    b = start;
    for (int i = 0; i < n; i++) begin
      send_byte(b);
      b = b + step;
    end
  endtask

  task automatic ack;
    block_ack = 1'b1;
    @(posedge clk);
    #1;
    block_ack = 1'b0;
  endtask

  task automatic do_reset;
    #2;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"},   block_out, '0);
    chk({tag, "_valid"}, {127'b0, block_valid}, 128'd0);
    chk({tag, "_count"}, {124'b0, byte_count}, 128'd0);
    chk({tag, "_ovf"},   {127'b0, overflow}, 128'd0);
    chk({tag, "_to"},    {127'b0, timeout}, 128'd0);
  endtask

  logic [127:0] blk_a, blk_b, blk_c;
  int           pulses_before;

  initial begin
    reset = 1'b0; rx_data = 8'h00; rx_done = 1'b0; block_ack = 1'b0;
    #12;
    chk_zero("por");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-run, observed before the next edge.
    send_bytes(8'hA0, 8'h01, 3);
    chk("pre_rst_count", {124'b0, byte_count}, 128'd3);
    #2; reset = 1'b0; #1;
    chk_zero("async_rst");
    #1; reset = 1'b1;
    @(posedge clk); #1;

    send_bytes(8'h00, 8'h11, 16);
    chk("blk1", block_out, 128'h00112233445566778899aabbccddeeff);
    chk("blk1_valid", {127'b0, block_valid}, 128'd1);
    chk("blk1_count", {124'b0, byte_count}, 128'd0);

    ack();
    chk("ack_valid", {127'b0, block_valid}, 128'd0);
    chk("ack_hold", block_out, 128'h00112233445566778899aabbccddeeff);

    // Overflow: A completes, B completes without ack.
    blk_a = mk(8'h10, 8'h03);
    blk_b = mk(8'hF0, 8'h07);
    send_bytes(8'h10, 8'h03, 16);
    chk("blkA", block_out, blk_a);
    chk("blkA_valid", {127'b0, block_valid}, 128'd1);
    chk("blkA_ovf", {127'b0, overflow}, 128'd0);
    send_bytes(8'hF0, 8'h07, 16);
    chk("ovf_out", block_out, blk_a);
    chk("ovf_flag", {127'b0, overflow}, 128'd1);
    chk("ovf_count", {124'b0, byte_count}, 128'd0);
    ack();
    chk("ovf_sticky", {127'b0, overflow}, 128'd1);

    // Ack in the same cycle as the 16th byte of B.
    do_reset();
    send_bytes(8'h10, 8'h03, 16);
    send_bytes(8'hF0, 8'h07, 15);
    block_ack = 1'b1;
    send_byte(8'hF0 + 8'd105);
    block_ack = 1'b0;
    chk("simul_out", block_out, blk_b);
    chk("simul_valid", {127'b0, block_valid}, 128'd1);
    chk("simul_ovf", {127'b0, overflow}, 128'd0);
    ack();

    // Timeout after 50 idle cycles.
    send_bytes(8'h55, 8'h01, 5);
    repeat (49) @(posedge clk);
    #1;
    chk("to_49_count", {124'b0, byte_count}, 128'd5);
    chk("to_49_pulse", {127'b0, timeout}, 128'd0);
    @(posedge clk); #1;
    chk("to_50_pulse", {127'b0, timeout}, 128'd1);
    chk("to_50_count", {124'b0, byte_count}, 128'd0);
    @(posedge clk); #1;
    chk("to_pulse_end", {127'b0, timeout}, 128'd0);
    chk("to_pulse_once", pulses, 128'd1);
    chk("to_keep_valid", {127'b0, block_valid}, 128'd0);
    send_bytes(8'h00, 8'h11, 16);
    chk("to_clean_blk", block_out, 128'h00112233445566778899aabbccddeeff);
    ack();

    // 6th byte on the exact limit cycle wins over the timeout.
    pulses_before = pulses;
    send_bytes(8'h20, 8'h01, 5);
    repeat (49) @(posedge clk);
    #1;
    send_byte(8'h25);
    chk("race_count", {124'b0, byte_count}, 128'd6);
    chk("race_pulse", {127'b0, timeout}, 128'd0);
    @(posedge clk); #1;
    chk("race_nopulse", pulses - pulses_before, 128'd0);

    // Reset mid-fill, then a clean block.
    do_reset();
    send_bytes(8'h77, 8'h01, 7);
    chk("mid_count7", {124'b0, byte_count}, 128'd7);
    #2; reset = 1'b0; #1;
    chk("mid_rst_count", {124'b0, byte_count}, 128'd0);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    blk_c = mk(8'h81, 8'h0B);
    send_bytes(8'h81, 8'h0B, 15);
    chk("mid_count15", {124'b0, byte_count}, 128'd15);
    send_byte(8'h81 + 8'd165);
    chk("mid_blk", block_out, blk_c);
    chk("mid_valid", {127'b0, block_valid}, 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/receiver_buffer.md
# receiver_buffer

Collects the byte stream delivered by the UART receiver into 128-bit blocks for the AES core. It is the receive-side counterpart of the transmit buffer, which splits a 128-bit block into bytes for the UART transmitter. It is double-buffered, so the next block can be assembled while the AES core still holds the previous one. It also discards stale partial blocks after an inter-byte timeout.

## Interface
- `TIMEOUT_CYCLES`, default 100000: idle clocks allowed between bytes of a partial block. 0 disables the timeout.
- `clk  input  1`: single clock. All logic is on the rising edge.
- `reset  input  1`: asynchronous, active-low reset. Low clears all state immediately, independent of `clk`.
- `rx_data  input  8`: received byte. Valid only while `rx_done`=1.
- `rx_done  input  1`: one-cycle strobe from the UART receiver marking a new byte on `rx_data`.
- `block_ack  input  1`: one-cycle strobe from the AES side. The current `block_out` has been consumed.
- `block_out  output  128`: assembled block, held stable while `block_valid`=1.
- `block_valid  output  1`: `block_out` holds an unconsumed block.
- `byte_count  output  4`: number of bytes in the partial block under assembly (0..15).
- `overflow  output  1`: sticky error flag. A completed block was dropped because the output register was still full. Cleared only by reset.
- `timeout  output  1`: one-cycle pulse when a partial block is discarded by the timeout.

## Operation
- Byte ordering: the first byte received lands in `[127:120]` and the 16th byte in `[7:0]`. This matches transmit order, where the MSB byte is sent first.
- The assembly register is an internal 128-bit shift register. Each sampled `rx_done` shifts left by 8 and inserts `rx_data` at `[7:0]`.
- States:
  - IDLE (`byte_count`=0): wait for `rx_done`.
  - FILL (`byte_count` 1..15): accumulate bytes.
  - `rx_done` in IDLE → FILL with count 1.
  - `rx_done` in FILL at count <15 → increment.
  - `rx_done` at count 15 (block completion) → IDLE with count 0.
- Block completion:
  - If `block_valid`=0, or `block_ack`=1 in the same cycle: load `block_out` with the completed 128 bits and set `block_valid`=1.
  - Otherwise: the completed block is dropped, `block_out` is unchanged, `overflow` is set to 1, and assembly returns to IDLE.
- `block_ack` with `block_valid`=1 and no completion in that cycle: `block_valid` goes to 0 and `block_out` holds its last value.
- `block_ack` with `block_valid`=0: ignored.
- Timeout:
  - An idle counter clears on every `rx_done` and increments every other cycle while in FILL.
  - When it reaches `TIMEOUT_CYCLES`, without a new `rx_done`: `byte_count` goes to 0, the partial data is discarded, and `timeout` pulses for one cycle.
  - If `rx_done` arrives in the same cycle the limit is reached, `rx_done` wins and the byte is accepted.
  - The counter does not run in IDLE.
  - The timeout never affects `block_out`, `block_valid` or `overflow`.
- Arithmetic and widths:
  - The idle counter is sized to hold `TIMEOUT_CYCLES` and saturates, so it never wraps.
  - `byte_count` never exceeds 15.

## Timing
- Reset values: `block_out`=0, `block_valid`=0, `byte_count`=0, `overflow`=0, `timeout`=0, assembly register=0, idle counter=0.
- All outputs are registered. There is no combinational path from any input to any output.
- Completion latency: on the rising edge that samples the 16th `rx_done`, `block_out` and `block_valid` update, and both are visible immediately after that edge.
- Acknowledge: `block_ack` sampled at edge N causes `block_valid`=0 after edge N.
- Back-to-back strobes: `rx_done` on consecutive cycles is accepted. There is no minimum spacing between bytes.
- Reset asserted mid-fill or with `block_valid`=1: all state clears asynchronously. The first `rx_done` after reset release starts a new block at count 1.

## Test plan
- Reset check: assert reset low mid-run → all outputs read 0 before the next clock edge. After release, send bytes 00,11,…,ff → `block_out`=128'h00112233445566778899aabbccddeeff and `block_valid`=1 one edge after the 16th strobe.
- Acknowledge: pulse `block_ack` once → `block_valid`=0, `block_out` unchanged. Send 16 more bytes (consecutive-cycle strobes) → new block valid, `overflow`=0.
- Overflow: complete block A and do not ack, then complete block B → `block_out`=A, `overflow`=1 (sticky), `byte_count`=0.
- Simultaneous events: `block_ack` in the same cycle as the 16th `rx_done` of block B → `block_out`=B, `block_valid` stays 1, `overflow`=0.
- Timeout, with `TIMEOUT_CYCLES`=50:
  - Send 5 bytes, then idle for 50 cycles → one `timeout` pulse and `byte_count`=0. Then send 00..ff → correct block, with no stale bytes.
  - Send 5 bytes and deliver the 6th byte exactly at cycle 50 → byte accepted, `byte_count`=6, no pulse.
- Reset mid-fill: after 7 bytes, pulse reset low → `byte_count`=0. Then a full 16-byte block → exact expected value.
